// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit (1), data MSB first,
// optional parity, stop bits (0); idle line level is 0.
module serial_frame_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_LEN   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              Dout,
  output logic              BUSY,
  output logic              DONE,
  output logic              DROP
);

  // Counter is shared by the data phase (DATA_W-1 down to 0) and the stop phase.
  localparam int unsigned CNT_MAX = (DATA_W > STOP_LEN) ? DATA_W : STOP_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic frame_parity(input logic [DATA_W-1:0] word);
    frame_parity = (^word) ^ (PARITY_ODD != 0);
  endfunction

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                par_r, par_s;
  logic                dout_r, dout_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                drop_r, drop_s;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      shift_r <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      par_r   <= 1'b0;
      dout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      par_r   <= par_s;
      dout_r  <= dout_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      drop_r  <= drop_s;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    par_s   = par_r;
    dout_s  = dout_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    // A request that lands while a frame is in flight (including the STOP exit edge) is lost.
    drop_s  = LOAD & busy_r;

    case (state_r)
      ST_IDLE: begin
        dout_s = 1'b0;
        if (LOAD) begin
          state_s = ST_START;
          shift_s = DATA_IN;
          par_s   = frame_parity(DATA_IN);
          dout_s  = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        state_s = ST_DATA;
        dout_s  = shift_r[DATA_W-1];
        shift_s = {shift_r[DATA_W-2:0], 1'b0};
        cnt_s   = CNT_W'(DATA_W - 1);
      end

      ST_DATA: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          if (PARITY_EN != 0) begin
            state_s = ST_PARITY;
            dout_s  = par_r;
          end else begin
            state_s = ST_STOP;
            dout_s  = 1'b0;
            cnt_s   = CNT_W'(STOP_LEN - 1);
          end
        end else begin
          dout_s  = shift_r[DATA_W-1];
          shift_s = {shift_r[DATA_W-2:0], 1'b0};
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end

      ST_PARITY: begin
        state_s = ST_STOP;
        dout_s  = 1'b0;
        cnt_s   = CNT_W'(STOP_LEN - 1);
      end

      ST_STOP: begin
        dout_s = 1'b0;
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end

      default: begin
        state_s = ST_IDLE;
        shift_s = {DATA_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        par_s   = 1'b0;
        dout_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign Dout = dout_r;
  assign BUSY = busy_r;
  assign DONE = done_r;
  assign DROP = drop_r;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default, odd-parity and
// no-parity/two-stop-bit instances share one stimulus stream.
module tb_serial_frame_tx;

  logic       CLK     = 1'b0;
  logic       RST     = 1'b1;
  logic       LOAD    = 1'b0;
  logic [7:0] DATA_IN = 8'h00;

  logic dout_d, busy_d, done_d, drop_d;
  logic dout_o, busy_o, done_o, drop_o;
  logic dout_n, busy_n, done_n, drop_n;

  int n_cmp = 0;
  int n_err = 0;

  serial_frame_tx dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA_IN(DATA_IN),
    .Dout(dout_d), .BUSY(busy_d), .DONE(done_d), .DROP(drop_d)
  );

  serial_frame_tx #(.PARITY_ODD(1)) dut_odd (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA_IN(DATA_IN),
    .Dout(dout_o), .BUSY(busy_o), .DONE(done_o), .DROP(drop_o)
  );

  serial_frame_tx #(.PARITY_EN(0), .STOP_LEN(2)) dut_np (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA_IN(DATA_IN),
    .Dout(dout_n), .BUSY(busy_n), .DONE(done_n), .DROP(drop_n)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, dout_d, 1'b0);
    chk({tag, "_busy"}, busy_d, 1'b0);
    chk({tag, "_done"}, done_d, 1'b0);
    chk({tag, "_drop"}, drop_d, 1'b0);
    chk({tag, "_busy_o"}, busy_o, 1'b0);
    chk({tag, "_busy_n"}, busy_n, 1'b0);
  endtask

  // Called just after E0; checks the 11 frame cycles and the DONE cycle.
  // load_at >= 0 raises LOAD for the edge that ends cycle load_at.
  task automatic frame_body(input string tag, input logic [10:0] e_def,
                            input logic [10:0] e_odd, input logic [10:0] e_np,
                            input int load_at);
    for (int i = 0; i < 11; i++) begin
      LOAD = (i == load_at);
      chk($sformatf("%s_dout%0d", tag, i), dout_d, e_def[10-i]);
      chk($sformatf("%s_dout_odd%0d", tag, i), dout_o, e_odd[10-i]);
      chk($sformatf("%s_dout_np%0d", tag, i), dout_n, e_np[10-i]);
      chk($sformatf("%s_busy%0d", tag, i), {busy_d, busy_o, busy_n}, 3'b111);
      chk($sformatf("%s_done%0d", tag, i), {done_d, done_o, done_n}, 3'b000);
      chk($sformatf("%s_drop%0d", tag, i), drop_d, (load_at >= 0 && i == load_at + 1));
      tick();
    end
    chk({tag, "_end_dout"}, {dout_d, dout_o, dout_n}, 3'b000);
    chk({tag, "_end_busy"}, {busy_d, busy_o, busy_n}, 3'b000);
    chk({tag, "_end_done"}, {done_d, done_o, done_n}, 3'b111);
    chk({tag, "_end_drop"}, drop_d, (load_at == 10));
  endtask

  task automatic start_frame(input logic [7:0] d);
    DATA_IN = d;
    LOAD    = 1'b1;
    tick();
    LOAD    = 1'b0;
  endtask

  initial begin
    // Asynchronous reset, held across edges even with LOAD asserted.
    #1 RST = 1'b0;
    #1 chk_idle("rst_async");
    LOAD    = 1'b1;
    DATA_IN = 8'hA5;
    tick();
    tick();
    chk_idle("rst_hold");
    LOAD = 1'b0;
    RST  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i));
    end

    // Plain A5 frame.
    start_frame(8'hA5);
    frame_body("a5", 11'b11010010100, 11'b11010010110, 11'b11010010100, -1);
    tick();
    chk_idle("a5_after");

    // 07: parity 1 even, 0 odd; no-parity variant ends in two stop bits.
    start_frame(8'h07);
    frame_body("x07", 11'b10000011110, 11'b10000011100, 11'b10000011100, -1);
    tick();
    chk_idle("x07_after");

    // LOAD with FF during an A5 frame is dropped; frame and data unchanged.
    start_frame(8'hA5);
    DATA_IN = 8'hFF;
    frame_body("drop", 11'b11010010100, 11'b11010010110, 11'b11010010100, 3);
    tick();
    chk_idle("drop_after1");
    tick();
    chk_idle("drop_after2");

    // Reset during the 6th data bit aborts the frame without DONE.
    start_frame(8'hA5);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_dout", dout_d, 1'b1);
    chk("mid_busy", busy_d, 1'b1);
    #2 RST = 1'b0;
    #1 chk_idle("mid_rst");
    chk("mid_rst_dout_o", dout_o, 1'b0);
    tick();
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("post_rst_done%0d", i), {done_d, busy_d}, 2'b00);
    end
    start_frame(8'h3C);
    frame_body("x3c", 11'b10011110000, 11'b10011110010, 11'b10011110000, -1);
    tick();
    chk_idle("x3c_after");

    // LOAD held across the frame boundary: one idle cycle, DROP on STOP exit.
    start_frame(8'hA5);
    DATA_IN = 8'h5A;
    frame_body("chain1", 11'b11010010100, 11'b11010010110, 11'b11010010100, 10);
    tick();
    frame_body("chain2", 11'b10101101000, 11'b10101101010, 11'b10101101000, -1);
    tick();
    chk_idle("chain_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
